// File: rtl/gpio_bank_pkg.sv
// Shared register map for the GPIO bank: top-level decode and benches use these indices.
package gpio_bank_pkg;

  localparam int GPIO_ADDR_W = 3;

  localparam logic [GPIO_ADDR_W-1:0] GPIO_DATA    = 3'd0;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_DIR     = 3'd1;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_SET     = 3'd2;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_CLR     = 3'd3;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_TGL     = 3'd4;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_RISE_EN = 3'd5;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_FALL_EN = 3'd6;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_PEND    = 3'd7;

  localparam int GPIO_MAX_WIDTH = 16;

endpackage

// File: rtl/gpio_bank_sync.sv
// Per-pin input synchroniser with a trailing "prev" flop; emits raw (unmasked) edges.
module gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // stage 0 is the metastability catcher, stage SYNC_STAGES-1 is the usable value
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_ff;
  logic [WIDTH-1:0]                  prev_q;

  // shift the raw pad value through the chain, then remember last cycle's settled value
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync_ff <= '0;
      prev_q  <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
      prev_q  <= sync_ff[SYNC_STAGES-1];
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Parametrised bidirectional GPIO bank on the J1 IO bus: output latch with atomic
// set/clear/toggle, direction, synchronised inputs, edge-pending bits and a level irq.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic                   clk,
  input  logic                   resetq,
  input  logic                   cs,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [GPIO_ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]       wd,
  output logic [WIDTH-1:0]       rdata,
  input  logic [WIDTH-1:0]       pin_in,
  output logic [WIDTH-1:0]       pin_out,
  output logic [WIDTH-1:0]       pin_oe,
  output logic                   irq
);

  // counter must reach SYNC_STAGES+1 and hold there
  localparam int                 WCNT_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [WCNT_W-1:0]  WCNT_MAX = WCNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]  out_q, dir_q, rise_en_q, fall_en_q, pend_q;
  logic [WCNT_W-1:0] warm_cnt;
  logic              warm;
  logic              wr_en;
  logic [WIDTH-1:0]  sync_q, raw_rise, raw_fall;
  logic [WIDTH-1:0]  rise, fall, clr_mask;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .resetq (resetq),
    .d      (pin_in),
    .sync_q (sync_q),
    .rise   (raw_rise),
    .fall   (raw_fall)
  );

  assign wr_en = cs & wr;
  assign warm  = (warm_cnt == WCNT_MAX);

  // edges only count once the chain has flushed its reset zeros, and only where enabled
  assign rise     = raw_rise & rise_en_q & {WIDTH{warm}};
  assign fall     = raw_fall & fall_en_q & {WIDTH{warm}};
  assign clr_mask = (wr_en && addr == GPIO_PEND) ? wd : '0;

  // warmup counter: count up from reset, then stick at the top
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)   warm_cnt <= '0;
    else if (!warm) warm_cnt <= warm_cnt + 1'b1;
  end

  // register file writes, including the atomic latch operations
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      out_q     <= OUT_RESET;
      dir_q     <= DIR_RESET;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr_en) begin
      case (addr)
        GPIO_DATA:    out_q     <= wd;
        GPIO_DIR:     dir_q     <= wd;
        GPIO_SET:     out_q     <= out_q | wd;
        GPIO_CLR:     out_q     <= out_q & ~wd;
        GPIO_TGL:     out_q     <= out_q ^ wd;
        GPIO_RISE_EN: rise_en_q <= wd;
        GPIO_FALL_EN: fall_en_q <= wd;
        default:      ;
      endcase
    end
  end

  // sticky pending bits; a new edge beats a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) pend_q <= '0;
    else         pend_q <= (pend_q & ~clr_mask) | rise | fall;
  end

  // level interrupt, registered so it trails pend by one cycle
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) irq <= 1'b0;
    else         irq <= |pend_q;
  end

  // read mux; zero when not addressed so banks can be ORed onto io_din
  always_comb begin
    rdata = '0;
    if (cs && rd) begin
      case (addr)
        GPIO_DATA:                   rdata = sync_q;
        GPIO_DIR:                    rdata = dir_q;
        GPIO_SET, GPIO_CLR, GPIO_TGL: rdata = out_q;
        GPIO_RISE_EN:                rdata = rise_en_q;
        GPIO_FALL_EN:                rdata = fall_en_q;
        GPIO_PEND:                   rdata = pend_q;
        default:                     rdata = '0;
      endcase
    end
  end

  assign pin_out = out_q;
  assign pin_oe  = dir_q;

endmodule
